// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two
// requesters, with a 3-state IDLE/EXEC/RESP handshake FSM.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for port N (N = 0, 1)
//   reqN_srca/srcb/ctrl          request operands and ALU op code
//   alu_srca/srcb/control        latched operands driven to the shared ALU
//   alu_result, alu_zero         combinational ALU return
//   rspN_valid / rspN_ready      response handshake for port N
//   rsp_result, rsp_zero         registered response data, shared by both ports
//   busy                         high while an operation is in flight
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [2:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic [2:0]       req1_ctrl,

    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,

    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             ptr;
    logic             gnt;
    logic             settle;
    logic             any_valid;
    logic             pick;
    logic             take;
    logic             rsp_fire;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [2:0]       op;

    // settle blocks acceptance for the first cycle after reset is released
    always_comb begin
        any_valid = req0_valid | req1_valid;
        // ptr names the preferred port; fall back to the other one
        pick      = ptr ? req1_valid : ~req0_valid;
        take      = (state == IDLE) & any_valid & ~reset & ~settle;
        rsp_fire  = gnt ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        req0_ready  = take & ~pick;
        req1_ready  = take & pick;
        rsp0_valid  = (state == RESP) & ~gnt & ~reset;
        rsp1_valid  = (state == RESP) & gnt & ~reset;
        busy        = (state != IDLE) & ~reset;
        alu_srca    = opa;
        alu_srcb    = opb;
        alu_control = op;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (take) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            gnt        <= 1'b0;
            settle     <= 1'b1;
            opa        <= '0;
            opb        <= '0;
            op         <= 3'b000;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            settle <= 1'b0;
            state  <= state_nxt;
            if (take) begin
                gnt <= pick;
                opa <= pick ? req1_srca : req0_srca;
                opb <= pick ? req1_srcb : req0_srcb;
                op  <= pick ? req1_ctrl : req0_ctrl;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
            end
            // hand priority to the port that was not just served
            if (state == RESP && rsp_fire) begin
                ptr <= ~gnt;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a transaction-level
// reference model, an external ALU model, directed and random stimulus.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [2:0]  alu_control;
    logic        alu_zero;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_ctrl(req1_ctrl),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External ALU; codes outside the usual set return an arbitrary mix
    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b,
                                          logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return {31'b0, $signed(a) < $signed(b)};
            default: return a ^ ~b ^ {29'b0, c};
        endcase
    endfunction

    assign alu_result = alu_f(alu_srca, alu_srcb, alu_control);
    assign alu_zero   = (alu_result == 32'b0);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input int cyc);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit          port;
        logic [31:0] res;
        bit          zero;
        int          due;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    exp_t n;
    int   cyc     = 0;
    int   free_at = 0;
    bit   pref    = 1'b0;
    bit   blk     = 1'b1;
    bit   acc;
    bit   port;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_ready0", req0_ready, 0, cyc);
            chk("rst_ready1", req1_ready, 0, cyc);
            chk("rst_valid0", rsp0_valid, 0, cyc);
            chk("rst_valid1", rsp1_valid, 0, cyc);
            chk("rst_busy", busy, 0, cyc);
            exp_q.delete();
            pref    = 1'b0;
            blk     = 1'b1;
            free_at = 0;
        end else begin
            if (blk) begin
                chk("post_rst_srca", alu_srca, 0, cyc);
                chk("post_rst_srcb", alu_srcb, 0, cyc);
                chk("post_rst_ctrl", alu_control, 0, cyc);
                chk("post_rst_result", rsp_result, 0, cyc);
                chk("post_rst_zero", rsp_zero, 0, cyc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("busy_hi", busy, 1, cyc);
                chk("alu_srca", alu_srca, e.a, cyc);
                chk("alu_srcb", alu_srcb, e.b, cyc);
                chk("alu_ctrl", alu_control, 32'(e.c), cyc);
                if (cyc >= e.due) begin
                    chk("rsp0_valid", rsp0_valid, 32'(e.port == 1'b0), cyc);
                    chk("rsp1_valid", rsp1_valid, 32'(e.port == 1'b1), cyc);
                    chk("rsp_result", rsp_result, e.res, cyc);
                    chk("rsp_zero", rsp_zero, 32'(e.zero), cyc);
                    if (e.port ? rsp1_ready : rsp0_ready) begin
                        void'(exp_q.pop_front());
                        pref    = !e.port;
                        free_at = cyc + 1;
                    end
                end else begin
                    chk("early_valid0", rsp0_valid, 0, cyc);
                    chk("early_valid1", rsp1_valid, 0, cyc);
                end
            end else begin
                chk("busy_lo", busy, 0, cyc);
                chk("idle_valid0", rsp0_valid, 0, cyc);
                chk("idle_valid1", rsp1_valid, 0, cyc);
            end
            acc  = !blk && exp_q.size() == 0 && cyc >= free_at &&
                   (req0_valid || req1_valid);
            port = pref ? (req1_valid ? 1'b1 : 1'b0)
                        : (req0_valid ? 1'b0 : 1'b1);
            chk("req0_ready", req0_ready, 32'(acc && port == 1'b0), cyc);
            chk("req1_ready", req1_ready, 32'(acc && port == 1'b1), cyc);
            if (acc) begin
                n.port = port;
                n.a    = port ? req1_srca : req0_srca;
                n.b    = port ? req1_srcb : req0_srcb;
                n.c    = port ? req1_ctrl : req0_ctrl;
                n.res  = alu_f(n.a, n.b, n.c);
                n.zero = (n.res == 32'b0);
                n.due  = cyc + 2;
                exp_q.push_back(n);
            end
            blk = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_take(input bit p);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        cyc_step();
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout port=%0d got=none want=ready", p);
        end
    endtask

    task automatic send(input bit p, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] c);
        if (p) begin
            req1_srca = a; req1_srcb = b; req1_ctrl = c; req1_valid = 1'b1;
        end else begin
            req0_srca = a; req0_srcb = b; req0_ctrl = c; req0_valid = 1'b1;
        end
        wait_take(p);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_srca = 0; req0_srcb = 0; req0_ctrl = 0;
        req1_srca = 0; req1_srcb = 0; req1_ctrl = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (3) cyc_step();
        reset = 1'b0;
        repeat (2) cyc_step();

        // port 0 add, then port 1 subtract to zero
        send(1'b0, 32'd5, 32'd3, 3'b010);
        repeat (4) cyc_step();
        send(1'b1, 32'd7, 32'd7, 3'b110);
        repeat (4) cyc_step();

        // both ports continuously valid: grants alternate
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 14; i++) begin
            req0_srca = $urandom; req0_srcb = $urandom;
            req0_ctrl = 3'($urandom_range(0, 7));
            req1_srca = $urandom; req1_srcb = $urandom;
            req1_ctrl = 3'($urandom_range(0, 7));
            cyc_step();
        end
        req0_valid = 0; req1_valid = 0;
        repeat (4) cyc_step();

        // response backpressure with port 1 waiting
        rsp0_ready = 0;
        send(1'b0, 32'h1234, 32'h1111, 3'b001);
        req1_srca = 32'd9; req1_srcb = 32'd4; req1_ctrl = 3'b110;
        req1_valid = 1;
        repeat (6) cyc_step();
        rsp0_ready = 1;
        wait_take(1'b1);
        repeat (4) cyc_step();

        // reset while in EXEC; pointer must return to port 0
        send(1'b0, 32'd1, 32'd2, 3'b010);
        repeat (4) cyc_step();
        send(1'b1, 32'd3, 32'd4, 3'b010);
        reset = 1'b1;
        cyc_step();
        reset = 1'b0;
        req0_srca = 32'd10; req0_srcb = 32'd20; req0_ctrl = 3'b010;
        req1_srca = 32'd30; req1_srcb = 32'd40; req1_ctrl = 3'b010;
        req0_valid = 1; req1_valid = 1;
        wait_take(1'b0);
        req1_valid = 0;
        repeat (4) cyc_step();

        // wrong-port response ready is ignored
        rsp0_ready = 0; rsp1_ready = 1;
        send(1'b0, 32'hffff_0000, 32'h0000_ffff, 3'b011);
        repeat (5) cyc_step();
        rsp0_ready = 1;
        repeat (4) cyc_step();

        // random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_srca  = ($urandom_range(0, 7) == 0) ? req0_srcb : $urandom;
            req0_srcb  = $urandom;
            req0_ctrl  = 3'($urandom_range(0, 7));
            req1_srca  = $urandom;
            req1_srcb  = ($urandom_range(0, 7) == 0) ? req1_srca : $urandom;
            req1_ctrl  = 3'($urandom_range(0, 7));
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            cyc_step();
        end
        reset = 0; req0_valid = 0; req1_valid = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (6) cyc_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
